sdram_init_ctrl: RTL

Parametrised SDRAM power-up and re-initialisation sequencer, the successor of the fixed-timing init block. It issues WAIT → PRECHARGE-ALL → N×AUTO-REFRESH → MRS → optional EMRS, with every timing, count and mode-register field set by parameters. It also supports a runtime re-init request, which skips the power-up wait and loads a new mode-register value. It sits in front of the SDRAM command mux, and the arbiter holds off all other traffic until init_end is high.

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_delay_cnt.sv | 32 +++
 rtl/sdram_init_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the init sequencer.
//   - sdram_cmd_e  : {cs_n,ras_n,cas_n,we_n} command encodings
//   - init_state_e : init sequencer state encoding
//   - EMRS_BANK    : bank select used for the extended mode register
//   - mr_encode()  : packs mode-register fields into a 13-bit address value
package sdram_pkg;

    typedef enum logic [3:0] {
        CMD_MRS  = 4'b0000,
        CMD_AREF = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_BST  = 4'b0110,
        CMD_NOP  = 4'b0111
    } sdram_cmd_e;

    typedef enum logic [3:0] {
        ST_WAIT,
        ST_PRE,
        ST_TRP,
        ST_AREF,
        ST_TRFC,
        ST_MRS,
        ST_TMRD,
        ST_EMRS,
        ST_TEMRD,
        ST_DONE
    } init_state_e;

    localparam logic [1:0] EMRS_BANK = 2'b10;

    // wb: write-burst mode, cl: CAS latency, bt: burst type, bl: burst length
    function automatic logic [12:0] mr_encode(input logic       wb,
                                              input logic [2:0] cl,
                                              input logic       bt,
                                              input logic [2:0] bl);
        return {3'b000, wb, 2'b00, cl, bt, bl};
    endfunction

endpackage

// File: rtl/sdram_delay_cnt.sv
// Loadable saturating down-counter used for every timing gap of the init
// sequencer.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this edge (takes priority over counting)
//   load_val  : value to load
//   done      : high while the count is zero
// Loading N makes done go high N edges later; the count stops at zero.
module sdram_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up / re-initialisation sequencer:
//   WAIT -> PRECHARGE-ALL -> AREF_NUM x AUTO-REFRESH -> MRS -> (EMRS) -> DONE
// A re-init request accepted in DONE reloads the mode register from mr_val
// and reruns the sequence without the power-up wait.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   reinit_req  : re-init request, only honoured while init_end = 1
//   mr_val      : mode value for a re-init, captured on the accepting edge
//   init_cmd    : {cs_n,ras_n,cas_n,we_n}, one-cycle commands, NOP otherwise
//   init_bank   : bank address (all ones when idle)
//   init_addr   : address bus (all ones when idle)
//   init_end    : sequence complete
//   init_busy   : sequence in progress (~init_end)
//
// state    | meaning
// ---------+--------------------------------------------------
// WAIT     | power-up wait, or one-cycle lead-in after re-init
// PRE      | PRECHARGE-ALL on the bus
// TRP      | gap after PRECHARGE
// AREF     | AUTO-REFRESH on the bus
// TRFC     | gap after AUTO-REFRESH
// MRS      | mode register set on the bus
// TMRD     | gap after MRS
// EMRS     | extended mode register set on the bus
// TEMRD    | gap after EMRS
// DONE     | SDRAM usable, waiting for re-init request
module sdram_init_ctrl
    import sdram_pkg::*;
#(
    parameter int                ADDR_W     = 13,
    parameter int                BANK_W     = 2,
    parameter int                WAIT_CYC   = 20000,
    parameter int                TRP_CYC    = 2,
    parameter int                TRFC_CYC   = 7,
    parameter int                TMRD_CYC   = 3,
    parameter int                AREF_NUM   = 8,
    parameter logic [ADDR_W-1:0] MR_DEFAULT = 'h0037,
    parameter int                EMRS_EN    = 0,
    parameter logic [ADDR_W-1:0] EMRS_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reinit_req,
    input  logic [ADDR_W-1:0] mr_val,
    output logic [3:0]        init_cmd,
    output logic [BANK_W-1:0] init_bank,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_end,
    output logic              init_busy
);

    localparam int SPC_MAX = (TRP_CYC > TRFC_CYC) ?
                             ((TRP_CYC > TMRD_CYC) ? TRP_CYC : TMRD_CYC) :
                             ((TRFC_CYC > TMRD_CYC) ? TRFC_CYC : TMRD_CYC);
    localparam int SPC_W   = $clog2(SPC_MAX + 1);
    localparam int WAIT_W  = $clog2(WAIT_CYC + 1);
    localparam int CNT_W   = (WAIT_W > SPC_W) ? WAIT_W : SPC_W;

    if (ADDR_W < 11 || WAIT_CYC < 1 || TRP_CYC < 2 || TRFC_CYC < 2 ||
        TMRD_CYC < 2 || AREF_NUM < 1 || AREF_NUM > 15) begin : g_bad_param
        $error("sdram_init_ctrl: illegal parameter value");
    end

    init_state_e       state_q, state_d;
    logic              wait_armed_q;
    logic [3:0]        aref_cnt_q;
    logic [ADDR_W-1:0] mode_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_val;
    logic              cnt_done;
    logic              reinit_acc;

    sdram_cmd_e        cmd_d;
    logic [BANK_W-1:0] bank_d;
    logic [ADDR_W-1:0] addr_d;

    assign reinit_acc = init_end & reinit_req;

    sdram_delay_cnt #(.W(CNT_W)) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;

        case (state_q)
            // First WAIT cycle after reset arms the counter so that PRE
            // lands exactly WAIT_CYC edges after the arming edge.
            ST_WAIT: begin
                if (!wait_armed_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(WAIT_CYC - 1);
                end else if (cnt_done) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE:   state_d = ST_TRP;
            ST_TRP:   if (cnt_done) state_d = ST_AREF;
            ST_AREF:  state_d = ST_TRFC;
            ST_TRFC: begin
                if (cnt_done) begin
                    state_d = (aref_cnt_q >= 4'(AREF_NUM)) ? ST_MRS : ST_AREF;
                end
            end
            ST_MRS:   state_d = ST_TMRD;
            ST_TMRD:  if (cnt_done) state_d = (EMRS_EN != 0) ? ST_EMRS : ST_DONE;
            ST_EMRS:  state_d = ST_TEMRD;
            ST_TEMRD: if (cnt_done) state_d = ST_DONE;
            // Re-init goes through WAIT with a zero count: one lead-in
            // cycle, then PRE.
            ST_DONE: begin
                if (reinit_acc) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end
            end
            default:  state_d = ST_WAIT;
        endcase

        // Gap counter starts on the edge a command is issued; loading
        // gap-1 makes the next command appear exactly gap edges later.
        if (state_d != state_q) begin
            case (state_d)
                ST_PRE: begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TRP_CYC - 1);
                end
                ST_AREF: begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TRFC_CYC - 1);
                end
                ST_MRS, ST_EMRS: begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TMRD_CYC - 1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cmd_d  = CMD_NOP;
        bank_d = '1;
        addr_d = '1;
        case (state_d)
            ST_PRE:  cmd_d = CMD_PRE;
            ST_AREF: cmd_d = CMD_AREF;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                bank_d = '0;
                addr_d = mode_q;
            end
            ST_EMRS: begin
                cmd_d  = CMD_MRS;
                bank_d = BANK_W'(EMRS_BANK);
                addr_d = EMRS_VAL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            wait_armed_q <= 1'b0;
            aref_cnt_q   <= '0;
            mode_q       <= MR_DEFAULT;
            init_cmd     <= CMD_NOP;
            init_bank    <= '1;
            init_addr    <= '1;
            init_end     <= 1'b0;
            init_busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT) begin
                wait_armed_q <= 1'b1;
            end
            if (state_d == ST_PRE) begin
                aref_cnt_q <= '0;
            end else if (state_d == ST_AREF) begin
                aref_cnt_q <= aref_cnt_q + 4'd1;
            end
            if (reinit_acc) begin
                mode_q <= mr_val;
            end
            init_cmd  <= cmd_d;
            init_bank <= bank_d;
            init_addr <= addr_d;
            init_end  <= (state_d == ST_DONE);
            init_busy <= (state_d != ST_DONE);
        end
    end

endmodule
